local_store_pipe: RTL and testbench

LOCAL_STORE_PIPE -- requirements
Module: local_store_pipe

---
 rtl/spu_pkg.sv | 53 +++++
 rtl/wb_delay.sv | 51 +++++
 rtl/local_store_pipe.sv | 126 ++++++++++++
 tb/tb_local_store_pipe.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/spu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : spu_pkg
// Purpose  : Shared opcode/format constants and the load/store kind decoder
//            for the SPU local-store pipeline.
// Revision : 1.0  initial release
// ============================================================================
package spu_pkg;

  typedef enum logic [1:0] {
    NONE  = 2'd0,
    LOAD  = 2'd1,
    STORE = 2'd2
  } ls_kind_t;

  // Instruction format codes
  localparam logic [2:0]  c_fmt_x   = 3'd0;
  localparam logic [2:0]  c_fmt_d   = 3'd4;
  localparam logic [2:0]  c_fmt_a   = 3'd5;

  // Opcodes, already truncated to the width each format decodes
  localparam logic [10:0] c_op_lqx  = 11'b00111000100;
  localparam logic [10:0] c_op_stqx = 11'b00101000100;
  localparam logic [7:0]  c_op_lqd  = 8'b00110100;
  localparam logic [7:0]  c_op_stqd = 8'b00100100;
  localparam logic [8:0]  c_op_lqa  = 9'b001100001;
  localparam logic [8:0]  c_op_stqa = 9'b001000001;

  // Classify an instruction; anything unrecognised is a non-memory op.
  // op bit 0 (IBM numbering) is the MSB, so op[3:10] is the low 8 bits.
  function automatic ls_kind_t decode_ls(input logic [2:0] format, input logic [10:0] op);
    ls_kind_t kind;
    kind = NONE;
    case (format)
      c_fmt_x: begin
        if (op == c_op_lqx)       kind = LOAD;
        else if (op == c_op_stqx) kind = STORE;
      end
      c_fmt_d: begin
        if (op[7:0] == c_op_lqd)       kind = LOAD;
        else if (op[7:0] == c_op_stqd) kind = STORE;
      end
      c_fmt_a: begin
        if (op[8:0] == c_op_lqa)       kind = LOAD;
        else if (op[8:0] == c_op_stqa) kind = STORE;
      end
      default: kind = NONE;
    endcase
    return kind;
  endfunction

endpackage
`default_nettype wire

// File: rtl/wb_delay.sv
`default_nettype none
// ============================================================================
// Module   : wb_delay
// Purpose  : Fixed-length writeback delay line carrying value, target
//            register and write enable; LAT register stages.
// Revision : 1.0  initial release
// ============================================================================
module wb_delay #(
  parameter int LAT     = 6,
  parameter int QW_BITS = 128
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [QW_BITS-1:0] val_in,
  input  logic [6:0]         addr_in,
  input  logic               en_in,
  output logic [QW_BITS-1:0] val_out,
  output logic [6:0]         addr_out,
  output logic               en_out
);

  logic [QW_BITS-1:0] r_val  [LAT];
  logic [6:0]         r_addr [LAT];
  logic               r_en   [LAT];

  // Shift every stage forward each cycle; reset empties the line into bubbles
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < LAT; i++) begin
        r_val[i]  <= '0;
        r_addr[i] <= '0;
        r_en[i]   <= 1'b0;
      end
    end else begin
      r_val[0]  <= val_in;
      r_addr[0] <= addr_in;
      r_en[0]   <= en_in;
      for (int i = 1; i < LAT; i++) begin
        r_val[i]  <= r_val[i-1];
        r_addr[i] <= r_addr[i-1];
        r_en[i]   <= r_en[i-1];
      end
    end
  end

  assign val_out  = r_val[LAT-1];
  assign addr_out = r_addr[LAT-1];
  assign en_out   = r_en[LAT-1];

endmodule
`default_nettype wire

// File: rtl/local_store_pipe.sv
`default_nettype none
// ============================================================================
// Module   : local_store_pipe
// Purpose  : SPU local-store load/store pipe with a low-priority DMA port.
//            Loads write back LAT cycles after issue, stores commit at the
//            issue edge, DMA is granted only in cycles without SPU access.
// Revision : 1.0  initial release
// ============================================================================
module local_store_pipe
  import spu_pkg::*;
#(
  parameter int ADDR_BITS = 11,
  parameter int QW_BITS   = 128,
  parameter int LAT       = 6     // legal range 2..8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [10:0]        op,
  input  logic [2:0]         format,
  input  logic [6:0]         rt_addr,
  input  logic [QW_BITS-1:0] ra,
  input  logic [QW_BITS-1:0] rb,
  input  logic [QW_BITS-1:0] rt_st,
  input  logic [17:0]        imm,
  input  logic               reg_write,
  input  logic               branch_taken,
  input  logic               dma_req,
  input  logic               dma_we,
  input  logic [31:0]        dma_addr,
  input  logic [QW_BITS-1:0] dma_wdata,
  output logic               dma_ack,
  output logic [QW_BITS-1:0] dma_rdata,
  output logic [7:0]         dma_wait,
  output logic [QW_BITS-1:0] rt_wb,
  output logic [6:0]         rt_addr_wb,
  output logic               reg_write_wb
);

  localparam int c_depth = 2 ** ADDR_BITS;

  logic [QW_BITS-1:0]   r_mem [c_depth];
  logic                 r_live;

  ls_kind_t             w_kind;
  logic                 w_valid;
  logic                 w_load;
  logic                 w_store;
  logic [31:0]          w_ra;
  logic [31:0]          w_rb;
  logic [31:0]          w_ea;
  logic [ADDR_BITS-1:0] w_idx;
  logic [ADDR_BITS-1:0] w_dma_idx;
  logic                 w_unused;

  assign w_kind  = decode_ls(format, op);
  assign w_valid = (w_kind != NONE) && !branch_taken;
  assign w_load  = w_valid && (w_kind == LOAD);
  assign w_store = w_valid && (w_kind == STORE);

  // Preferred slot of each operand is the most significant word
  assign w_ra = ra[QW_BITS-1 -: 32];
  assign w_rb = rb[QW_BITS-1 -: 32];

  // Effective byte address per format, 32-bit wrap
  always_comb begin
    w_ea = '0;
    case (format)
      c_fmt_x: w_ea = w_ra + w_rb;
      c_fmt_d: w_ea = w_ra + {{18{imm[9]}}, imm[9:0], 4'b0000};
      c_fmt_a: w_ea = {{14{imm[15]}}, imm[15:0], 2'b00};
      default: w_ea = '0;
    endcase
  end

  // Quadword index; high address bits fall off so the store wraps around
  assign w_idx     = w_ea[ADDR_BITS+3:4];
  assign w_dma_idx = dma_addr[ADDR_BITS+3:4];

  // r_live keeps the combinational grant low while reset is held
  assign dma_ack = dma_req && !w_valid && r_live;

  // Tracks that the block has seen a clock edge since reset
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_live <= 1'b0;
    else        r_live <= 1'b1;
  end

  // Local-store array: SPU store and DMA write are mutually exclusive
  always_ff @(posedge clk) begin
    if (w_store)                 r_mem[w_idx]     <= rt_st;
    else if (dma_ack && dma_we)  r_mem[w_dma_idx] <= dma_wdata;
  end

  // DMA read data captured at the granting edge
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                  dma_rdata <= '0;
    else if (dma_ack && !dma_we) dma_rdata <= r_mem[w_dma_idx];
  end

  // Saturating count of consecutive denied DMA request cycles
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                   dma_wait <= '0;
    else if (!dma_req || dma_ack) dma_wait <= '0;
    else if (dma_wait != 8'hFF)   dma_wait <= dma_wait + 8'd1;
  end

  wb_delay #(
    .LAT     (LAT),
    .QW_BITS (QW_BITS)
  ) u_wb_delay (
    .clk      (clk),
    .reset    (reset),
    .val_in   (w_load ? r_mem[w_idx] : '0),
    .addr_in  (w_load ? rt_addr : 7'd0),
    .en_in    (w_load && reg_write),
    .val_out  (rt_wb),
    .addr_out (rt_addr_wb),
    .en_out   (reg_write_wb)
  );

  assign w_unused = ^{ra[QW_BITS-33:0], rb[QW_BITS-33:0], imm[17:16],
                      w_ea[31:ADDR_BITS+4], w_ea[3:0],
                      dma_addr[31:ADDR_BITS+4], dma_addr[3:0]};

endmodule
`default_nettype wire

// File: tb/tb_local_store_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_local_store_pipe
// Purpose  : Self-checking bench for local_store_pipe: vector table with a
//            writeback scoreboard plus DMA, saturation and reset sequences.
// Revision : 1.0  initial release
// ============================================================================
module tb_local_store_pipe;

  parameter int LAT = 6;
  localparam int AB = 11;
  localparam int QW = 128;

  localparam logic [10:0] OP_LQX  = 11'b00111000100;
  localparam logic [10:0] OP_STQX = 11'b00101000100;
  localparam logic [10:0] OP_LQD  = 11'b11100110100;  // junk above op[3:10]
  localparam logic [10:0] OP_STQD = 11'b00000100100;
  localparam logic [10:0] OP_LQA  = 11'b01001100001;  // junk above op[2:10]
  localparam logic [10:0] OP_STQA = 11'b00001000001;

  logic          clk = 1'b0;
  logic          reset;
  logic [10:0]   op;
  logic [2:0]    format;
  logic [6:0]    rt_addr;
  logic [QW-1:0] ra, rb, rt_st;
  logic [17:0]   imm;
  logic          reg_write, branch_taken;
  logic          dma_req, dma_we;
  logic [31:0]   dma_addr;
  logic [QW-1:0] dma_wdata;
  logic          dma_ack;
  logic [QW-1:0] dma_rdata;
  logic [7:0]    dma_wait;
  logic [QW-1:0] rt_wb;
  logic [6:0]    rt_addr_wb;
  logic          reg_write_wb;

  local_store_pipe #(.ADDR_BITS(AB), .QW_BITS(QW), .LAT(LAT)) dut (
    .clk(clk), .reset(reset), .op(op), .format(format), .rt_addr(rt_addr),
    .ra(ra), .rb(rb), .rt_st(rt_st), .imm(imm), .reg_write(reg_write),
    .branch_taken(branch_taken), .dma_req(dma_req), .dma_we(dma_we),
    .dma_addr(dma_addr), .dma_wdata(dma_wdata), .dma_ack(dma_ack),
    .dma_rdata(dma_rdata), .dma_wait(dma_wait), .rt_wb(rt_wb),
    .rt_addr_wb(rt_addr_wb), .reg_write_wb(reg_write_wb)
  );

  always #5 clk = ~clk;

  // kind: 0 non-memory, 1 load, 2 store; idx is the hand-computed line index
  typedef struct {
    int          kind;
    logic [2:0]  fmt;
    logic [10:0] op;
    logic [31:0] ra;
    logic [31:0] rb;
    logic [17:0] imm;
    logic [6:0]  rt;
    logic        rw;
    logic        bt;
    logic [QW-1:0] data;
    int          idx;
  } vec_t;

  typedef struct {
    logic [QW-1:0] val;
    logic [6:0]    addr;
    logic          en;
    bit            chk;
  } wb_t;

  logic [QW-1:0] mem_m [2**AB];
  bit            wr_m  [2**AB];
  wb_t           q[$];
  vec_t          tbl[$];
  int            checks = 0;
  int            errors = 0;
  int            m_wait = 0;
  bit            rd_pend = 1'b0;
  logic [QW-1:0] rd_val;
  vec_t          nop;

  function automatic vec_t mk(int kind, logic [2:0] fmt, logic [10:0] o, logic [31:0] a,
                              logic [31:0] b, logic [17:0] im, logic [6:0] rt, logic rw,
                              logic bt, logic [31:0] pat, int idx);
    vec_t v;
    v.kind = kind; v.fmt = fmt; v.op = o; v.ra = a; v.rb = b; v.imm = im;
    v.rt = rt; v.rw = rw; v.bt = bt; v.data = {4{pat}}; v.idx = idx;
    return v;
  endfunction

  task automatic check(input string name, input logic [QW-1:0] act, input logic [QW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual %0h required %0h", name, act, exp);
    end
  endtask

  task automatic reset_model();
    q.delete();
    for (int i = 0; i < LAT; i++) q.push_back('{val: '0, addr: '0, en: 1'b0, chk: 1'b1});
    m_wait  = 0;
    rd_pend = 1'b0;
  endtask

  // Called at a negedge: check matured outputs, drive one instruction, update model
  task automatic step(input vec_t v);
    wb_t  e;
    bit   valid, ack_exp;
    int   didx;
    e = q.pop_front();
    check("wb_en", reg_write_wb, e.en);
    check("wb_addr", rt_addr_wb, e.addr);
    if (e.chk) check("wb_val", rt_wb, e.val);
    check("dma_wait", dma_wait, m_wait);
    if (rd_pend) check("dma_rdata", dma_rdata, rd_val);

    op = v.op; format = v.fmt; rt_addr = v.rt; imm = v.imm;
    ra = {v.ra, $urandom, $urandom, $urandom};
    rb = {v.rb, $urandom, $urandom, $urandom};
    rt_st = v.data; reg_write = v.rw; branch_taken = v.bt;
    #1;
    valid   = (v.kind != 0) && !v.bt;
    ack_exp = dma_req && !valid;
    check("dma_ack", dma_ack, ack_exp);

    e = '{val: '0, addr: '0, en: 1'b0, chk: 1'b1};
    if (valid && v.kind == 1) begin
      e.val = mem_m[v.idx]; e.addr = v.rt; e.en = v.rw; e.chk = wr_m[v.idx];
    end
    if (valid && v.kind == 2) begin
      mem_m[v.idx] = v.data; wr_m[v.idx] = 1'b1;
    end
    q.push_back(e);

    rd_pend = 1'b0;
    if (ack_exp) begin
      didx = int'(dma_addr[AB+3:4]);
      if (dma_we) begin
        mem_m[didx] = dma_wdata; wr_m[didx] = 1'b1;
      end else begin
        rd_pend = wr_m[didx]; rd_val = mem_m[didx];
      end
    end
    m_wait = (dma_req && !ack_exp) ? ((m_wait == 255) ? 255 : m_wait + 1) : 0;
    @(negedge clk);
  endtask

  initial begin
    nop = mk(0, 3'd2, 11'd0, 32'd0, 32'd0, 18'd0, 7'd0, 1'b0, 1'b0, 32'd0, 0);

    // ----- vector table -------------------------------------------------------
    tbl.push_back(mk(2, 3'd0, OP_STQX, 32'h1000, 32'h70, 18'h0, 7'd0, 1'b0, 1'b0, 32'h11111111, 'h107));
    tbl.push_back(mk(2, 3'd4, OP_STQD, 32'h100, 32'h0, 18'h1, 7'd0, 1'b0, 1'b0, 32'hA5A5A5A5, 'h11));
    tbl.push_back(mk(1, 3'd4, OP_LQD, 32'h110, 32'h0, 18'h0, 7'd5, 1'b1, 1'b0, 32'h0, 'h11));
    tbl.push_back(mk(2, 3'd5, OP_STQA, 32'h0, 32'h0, 18'h0FFFF, 7'd0, 1'b0, 1'b0, 32'h22222222, 'h7FF));
    tbl.push_back(mk(2, 3'd0, OP_STQX, 32'h0, 32'h10, 18'h0, 7'd0, 1'b0, 1'b0, 32'h33333333, 1));
    tbl.push_back(mk(1, 3'd0, OP_LQX, 32'hFFFFFFF0, 32'h20, 18'h0, 7'd9, 1'b1, 1'b0, 32'h0, 1));
    tbl.push_back(mk(1, 3'd5, OP_LQA, 32'h0, 32'h0, 18'h3FFFF, 7'd10, 1'b1, 1'b0, 32'h0, 'h7FF));
    tbl.push_back(mk(2, 3'd0, OP_STQX, 32'h70, 32'h0, 18'h0, 7'd0, 1'b0, 1'b0, 32'h44444444, 7));
    tbl.push_back(mk(2, 3'd0, OP_STQX, 32'h70, 32'h0, 18'h0, 7'd0, 1'b0, 1'b1, 32'h55555555, 7));
    tbl.push_back(mk(1, 3'd0, OP_LQX, 32'h30, 32'h40, 18'h0, 7'd11, 1'b1, 1'b0, 32'h0, 7));
    tbl.push_back(mk(0, 3'd0, 11'd0, 32'h0, 32'h0, 18'h0, 7'd3, 1'b1, 1'b0, 32'h0, 0));
    tbl.push_back(mk(0, 3'd1, OP_LQX, 32'h0, 32'h10, 18'h0, 7'd4, 1'b1, 1'b0, 32'h0, 0));
    tbl.push_back(mk(1, 3'd0, OP_LQX, 32'h70, 32'h0, 18'h0, 7'd6, 1'b1, 1'b1, 32'h0, 7));
    tbl.push_back(mk(2, 3'd4, OP_STQD, 32'h1000, 32'h0, 18'h003FE, 7'd0, 1'b0, 1'b0, 32'h66666666, 'hFE));
    tbl.push_back(mk(1, 3'd0, OP_LQX, 32'hF00, 32'hE0, 18'h0, 7'd12, 1'b1, 1'b0, 32'h0, 'hFE));
    tbl.push_back(mk(1, 3'd0, OP_LQX, 32'h1070, 32'h0, 18'h0, 7'd14, 1'b0, 1'b0, 32'h0, 'h107));
    tbl.push_back(mk(2, 3'd5, OP_STQA, 32'h0, 32'h0, 18'h00010, 7'd0, 1'b0, 1'b0, 32'h77777777, 4));
    tbl.push_back(mk(1, 3'd4, OP_LQD, 32'h30, 32'h0, 18'h1, 7'd13, 1'b1, 1'b0, 32'h0, 4));
    tbl.push_back(mk(1, 3'd0, OP_LQX, 32'h7FFF0, 32'h0, 18'h0, 7'd15, 1'b1, 1'b0, 32'h0, 'h7FF));

    // ----- reset state --------------------------------------------------------
    reset = 1'b0; op = '0; format = '0; rt_addr = '0; ra = '0; rb = '0; rt_st = '0;
    imm = '0; reg_write = 1'b0; branch_taken = 1'b0;
    dma_req = 1'b1; dma_we = 1'b0; dma_addr = '0; dma_wdata = '0;
    repeat (3) @(negedge clk);
    check("rst_rt_wb", rt_wb, '0);
    check("rst_rt_addr_wb", rt_addr_wb, '0);
    check("rst_reg_write_wb", reg_write_wb, '0);
    check("rst_dma_ack", dma_ack, '0);
    check("rst_dma_wait", dma_wait, '0);
    check("rst_dma_rdata", dma_rdata, '0);
    dma_req = 1'b0;
    reset = 1'b1;
    reset_model();

    // ----- table ------------------------------------------------------------
    for (int i = 0; i < tbl.size(); i++) step(tbl[i]);
    repeat (LAT) step(nop);

    // ----- DMA write then read, priority against SPU --------------------------
    dma_req = 1'b1; dma_we = 1'b1; dma_addr = 32'h40; dma_wdata = 128'h1234;
    step(nop);
    dma_we = 1'b0;
    step(nop);
    dma_req = 1'b0;
    step(nop);
    step(mk(1, 3'd4, OP_LQD, 32'h40, 32'h0, 18'h0, 7'd2, 1'b1, 1'b0, 32'h0, 4));
    dma_req = 1'b1; dma_addr = 32'h70;
    step(mk(1, 3'd0, OP_LQX, 32'h70, 32'h0, 18'h0, 7'd8, 1'b1, 1'b0, 32'h0, 7));
    step(nop);
    dma_req = 1'b0;
    step(nop);
    dma_req = 1'b1; dma_addr = 32'h40;
    step(mk(2, 3'd0, OP_STQX, 32'h40, 32'h0, 18'h0, 7'd0, 1'b0, 1'b1, 32'h99999999, 4));
    dma_req = 1'b0;
    step(nop);

    // ----- DMA starvation under back-to-back loads ----------------------------
    dma_req = 1'b1; dma_we = 1'b0; dma_addr = 32'h10;
    for (int i = 0; i < 300; i++)
      step(mk(1, 3'd0, OP_LQX, 32'hFFFFFFF0, 32'h20, 18'h0, 7'd9, 1'b1, 1'b0, 32'h0, 1));
    step(nop);
    dma_req = 1'b0;
    step(nop);
    repeat (LAT) step(nop);

    // ----- reset with loads in flight -----------------------------------------
    step(mk(2, 3'd0, OP_STQX, 32'h200, 32'h0, 18'h0, 7'd0, 1'b0, 1'b0, 32'h88888888, 'h20));
    repeat (3) step(mk(1, 3'd0, OP_LQX, 32'h0, 32'h10, 18'h0, 7'd21, 1'b1, 1'b0, 32'h0, 1));
    reset = 1'b0;
    dma_req = 1'b1;
    #1;
    check("midrst_reg_write_wb", reg_write_wb, '0);
    check("midrst_rt_wb", rt_wb, '0);
    check("midrst_dma_ack", dma_ack, '0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("inrst_reg_write_wb", reg_write_wb, '0);
      check("inrst_dma_wait", dma_wait, '0);
    end
    dma_req = 1'b0;
    reset = 1'b1;
    reset_model();
    repeat (LAT + 2) step(nop);
    step(mk(1, 3'd0, OP_LQX, 32'h100, 32'h100, 18'h0, 7'd22, 1'b1, 1'b0, 32'h0, 'h20));
    repeat (LAT) step(nop);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
